// File: rtl/tdc_readout.sv
// tdc_readout: consumer end of the TDC measurement interface.
// Each measurement is turned into one interval in fine-bin units and queued
// in a small FIFO. Each queued result is then sent as a fixed 9-byte frame:
//   A5 | interval[55:0], MSB first | {drops[5:0], 1'b0, neg}
module tdc_readout #(
   parameter int         FINE_BITS   = 5,
   parameter int         COARSE_BITS = 48,
   parameter int         FIFO_DEPTH  = 8,
   parameter logic [7:0] HEADER      = 8'hA5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          meas_valid,
   input  logic [FINE_BITS-1:0]          bin_start,
   input  logic [FINE_BITS-1:0]          bin_stop,
   input  logic [COARSE_BITS-1:0]        coarse_count,
   output logic [7:0]                    tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   // Signed working width of the interval computation. It must satisfy
   // SW - 1 <= IVW so that a non-negative result always fits the 56-bit field.
   localparam int SW  = COARSE_BITS + FINE_BITS + 2;
   localparam int IVW = 56;
   localparam int EW  = IVW + 1;

   typedef enum logic [3:0] {
      IDLE,
      HDR,
      DATA0,
      DATA1,
      DATA2,
      DATA3,
      DATA4,
      DATA5,
      DATA6,
      STAT
   } state_t;

   state_t           state;
   state_t           state_n;

   logic [SW-1:0]    diff_c;
   logic             neg_c;
   logic [IVW-1:0]   interval_c;

   logic [EW-1:0]    mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             drop;
   logic             pop;
   logic             adv;

   logic [5:0]       drop_cnt;
   logic [IVW-1:0]   frame_interval;
   logic             frame_neg;
   logic [5:0]       frame_drops;

   logic             tx_valid_n;
   logic [7:0]       tx_data_n;

   // Interval arithmetic, evaluated combinationally in the meas_valid cycle.
   always_comb begin
      diff_c     = {2'b00, coarse_count, {FINE_BITS{1'b0}}}
                   + SW'(bin_start) - SW'(bin_stop);
      neg_c      = diff_c[SW-1];
      interval_c = '0;
      if (!neg_c) begin
         interval_c[SW-2:0] = diff_c[SW-2:0];
      end
   end

   // A measurement that finds the FIFO full at its write edge is lost, even
   // if the readout pops in that very cycle: fullness is judged before the pop.
   assign full  = (fifo_level == LW'(FIFO_DEPTH));
   assign empty = (fifo_level == '0);
   assign push  = meas_valid && !full;
   assign drop  = meas_valid && full;

   // FIFO storage; contents need no reset because fifo_level gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {interval_c, neg_c};
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Drop counter: saturates at 63, cleared when snapshotted into a frame.
   // A drop in the snapshot cycle itself is carried into the next frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt <= '0;
      end else if (pop) begin
         drop_cnt <= drop ? 6'd1 : 6'd0;
      end else if (drop && (drop_cnt != 6'd63)) begin
         drop_cnt <= drop_cnt + 6'd1;
      end
   end

   // Frame register: holds the result being sent, loaded at the pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_interval <= '0;
         frame_neg      <= 1'b0;
         frame_drops    <= '0;
      end else if (pop) begin
         {frame_interval, frame_neg} <= mem[rd_ptr];
         frame_drops                 <= drop_cnt;
      end
   end

   // Output stream handshake: a byte transfers on a rising edge where
   // tx_valid && tx_ready. Once tx_valid is raised, it and tx_data hold
   // unchanged until that transfer. tx_ready may change freely.
   assign adv = tx_valid && tx_ready;

   // State register plus registered stream outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         state    <= state_n;
         tx_valid <= tx_valid_n;
         tx_data  <= tx_data_n;
      end
   end

   // Next state, pop request, and the byte to present in the next state.
   always_comb begin
      state_n    = state;
      pop        = 1'b0;
      tx_valid_n = 1'b0;
      tx_data_n  = 8'h00;

      case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_n = HDR;
            end
         end
         HDR:     if (adv) state_n = DATA0;
         DATA0:   if (adv) state_n = DATA1;
         DATA1:   if (adv) state_n = DATA2;
         DATA2:   if (adv) state_n = DATA3;
         DATA3:   if (adv) state_n = DATA4;
         DATA4:   if (adv) state_n = DATA5;
         DATA5:   if (adv) state_n = DATA6;
         DATA6:   if (adv) state_n = STAT;
         STAT:    if (adv) state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // Bytes are derived from the frame register, which is stable for the
      // whole frame, so a stalled byte is re-presented unchanged.
      case (state_n)
         HDR: begin
            tx_valid_n = 1'b1;
            tx_data_n  = HEADER;
         end
         DATA0: begin
            tx_valid_n = 1'b1;
            tx_data_n  = frame_interval[55:48];
         end
         DATA1: begin
            tx_valid_n = 1'b1;
            tx_data_n  = frame_interval[47:40];
         end
         DATA2: begin
            tx_valid_n = 1'b1;
            tx_data_n  = frame_interval[39:32];
         end
         DATA3: begin
            tx_valid_n = 1'b1;
            tx_data_n  = frame_interval[31:24];
         end
         DATA4: begin
            tx_valid_n = 1'b1;
            tx_data_n  = frame_interval[23:16];
         end
         DATA5: begin
            tx_valid_n = 1'b1;
            tx_data_n  = frame_interval[15:8];
         end
         DATA6: begin
            tx_valid_n = 1'b1;
            tx_data_n  = frame_interval[7:0];
         end
         STAT: begin
            tx_valid_n = 1'b1;
            tx_data_n  = {frame_drops, 1'b0, frame_neg};
         end
         default: begin
            tx_valid_n = 1'b0;
            tx_data_n  = 8'h00;
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_tdc_readout.sv
// Bench for tdc_readout: table of known measurements, backpressure/overflow,
// random stream with a frame scoreboard, and reset in the middle of a frame.
module tb_tdc_readout;

   localparam int FIFO_DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        meas_valid;
   logic [4:0]  bin_start;
   logic [4:0]  bin_stop;
   logic [47:0] coarse_count;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [3:0]  fifo_level;
   logic        busy;

   typedef struct {
      logic [47:0] coarse;
      logic [4:0]  start;
      logic [4:0]  stop;
      logic [55:0] interval;
      logic        neg;
   } vec_t;

   vec_t        vecs [7];

   logic [71:0] exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          frames_done = 0;
   int          base_frames;
   logic [71:0] acc;
   int          acc_n;
   logic        held;
   logic [7:0]  held_byte;

   int          sent;
   int          gap;
   int          cycles;
   logic [63:0] rnd;
   logic [47:0] rc;
   logic [4:0]  rs;
   logic [4:0]  rp;

   tdc_readout #(
      .FINE_BITS   (5),
      .COARSE_BITS (48),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .HEADER      (8'hA5)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .meas_valid   (meas_valid),
      .bin_start    (bin_start),
      .bin_stop     (bin_stop),
      .coarse_count (coarse_count),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .fifo_level   (fifo_level),
      .busy         (busy)
   );

   // Clock: 10 time-unit period.
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [71:0] make_frame(input logic [55:0] interval, input logic [7:0] status);
      return {8'hA5, interval, status};
   endfunction

   // Reference model: interval = coarse*32 + start - stop, clamped at zero.
   function automatic logic [71:0] model_frame(input logic [47:0] c, input logic [4:0] s,
                                               input logic [4:0] p);
      logic [63:0] a;
      logic [63:0] b;
      a = {16'h0, c} * 64'd32 + {59'h0, s};
      b = {59'h0, p};
      if (a < b) return make_frame(56'h0, 8'h01);
      return make_frame(56'(a - b), 8'h00);
   endfunction

   // Stream monitor, sampled at the falling edge: assembles frames, compares
   // them with the scoreboard, and checks that stalled bytes are held.
   task automatic monitor();
      logic [71:0] exp_frame;
      if (reset) begin
         acc_n = 0;
         held  = 1'b0;
         return;
      end
      if (held) begin
         check("stall_hold", {63'h0, tx_valid, tx_data}, {63'h0, 1'b1, held_byte});
      end
      held      = tx_valid && !tx_ready;
      held_byte = tx_data;
      if (tx_valid && tx_ready) begin
         acc = {acc[63:0], tx_data};
         acc_n++;
         if (acc_n == 9) begin
            acc_n = 0;
            frames_done++;
            check("frame_expected", 72'(exp_q.size() != 0), 72'd1);
            if (exp_q.size() != 0) begin
               exp_frame = exp_q.pop_front();
               check("frame", acc, exp_frame);
            end
         end
      end
   endtask

   // One clock: monitor at the falling edge, return 1 time unit after the
   // next rising edge, where inputs for the following cycle are driven.
   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_meas(input logic [47:0] c, input logic [4:0] s, input logic [4:0] p);
      meas_valid   = 1'b1;
      coarse_count = c;
      bin_start    = s;
      bin_stop     = p;
   endtask

   task automatic wait_frames(input int target, input int budget);
      int n;
      n = 0;
      while (frames_done < target && n < budget) begin
         step();
         n++;
      end
      check("frames_done", 72'(frames_done), 72'(target));
   endtask

   initial begin
      reset        = 1'b1;
      meas_valid   = 1'b0;
      tx_ready     = 1'b0;
      bin_start    = '0;
      bin_stop     = '0;
      coarse_count = '0;
      acc          = '0;
      acc_n        = 0;
      held         = 1'b0;
      held_byte    = '0;

      vecs[0] = '{48'd3,               5'd10, 5'd4,  56'd102,              1'b0};
      vecs[1] = '{48'd0,               5'd2,  5'd9,  56'd0,                1'b1};
      vecs[2] = '{48'hFFFF_FFFF_FFFF,  5'd31, 5'd0,  56'h1F_FFFF_FFFF_FFFF, 1'b0};
      vecs[3] = '{48'd0,               5'd5,  5'd5,  56'd0,                1'b0};
      vecs[4] = '{48'd1,               5'd0,  5'd31, 56'd1,                1'b0};
      vecs[5] = '{48'd0,               5'd0,  5'd1,  56'd0,                1'b1};
      vecs[6] = '{48'h1234,            5'd7,  5'd3,  56'h24684,            1'b0};

      // Reset state.
      repeat (3) step();
      check("rst_tx_valid", 72'(tx_valid), 72'd0);
      check("rst_busy", 72'(busy), 72'd0);
      check("rst_level", 72'(fifo_level), 72'd0);
      check("rst_tx_data", 72'(tx_data), 72'd0);
      reset    = 1'b0;
      tx_ready = 1'b1;
      step();

      // Table-driven single measurements with free-running tx_ready.
      for (int i = 0; i < 7; i++) begin
         base_frames = frames_done;
         drive_meas(vecs[i].coarse, vecs[i].start, vecs[i].stop);
         exp_q.push_back(make_frame(vecs[i].interval, {7'h0, vecs[i].neg}));
         step();
         meas_valid = 1'b0;
         check("lat_level", 72'(fifo_level), 72'd1);
         check("lat_idle", 72'(tx_valid), 72'd0);
         step();
         check("hdr_valid", 72'(tx_valid), 72'd1);
         check("hdr_byte", 72'(tx_data), 72'hA5);
         check("hdr_busy", 72'(busy), 72'd1);
         check("pop_level", 72'(fifo_level), 72'd0);
         wait_frames(base_frames + 1, 40);
         step();
         check("idle_busy", 72'(busy), 72'd0);
      end

      // Backpressure and overflow: ten pulses with the stream stalled.
      tx_ready    = 1'b0;
      base_frames = frames_done;
      for (int i = 1; i <= 10; i++) begin
         drive_meas(48'(i), 5'd0, 5'd0);
         if (i <= 9) exp_q.push_back(make_frame(56'(32 * i), (i == 2) ? 8'h04 : 8'h00));
         step();
         meas_valid = 1'b0;
         step();
      end
      check("ovf_level", 72'(fifo_level), 72'd8);
      check("ovf_valid", 72'(tx_valid), 72'd1);
      check("ovf_byte", 72'(tx_data), 72'hA5);
      check("ovf_busy", 72'(busy), 72'd1);
      tx_ready = 1'b1;
      wait_frames(base_frames + 9, 200);
      step();
      check("ovf_drain_level", 72'(fifo_level), 72'd0);
      check("ovf_drain_busy", 72'(busy), 72'd0);

      // Random measurements with random tx_ready; never overfill the FIFO.
      sent   = 0;
      gap    = 0;
      cycles = 0;
      while (sent < 200 && cycles < 20000) begin
         tx_ready   = ($urandom_range(0, 3) != 0);
         meas_valid = 1'b0;
         if (gap != 0) begin
            gap--;
         end else if (exp_q.size() < FIFO_DEPTH) begin
            rnd = {$urandom(), $urandom()};
            rc  = ($urandom_range(0, 1) == 0) ? 48'($urandom_range(0, 3)) : rnd[47:0];
            rs  = 5'($urandom_range(0, 31));
            rp  = 5'($urandom_range(0, 31));
            drive_meas(rc, rs, rp);
            exp_q.push_back(model_frame(rc, rs, rp));
            sent++;
            gap = $urandom_range(0, 3);
         end
         step();
         cycles++;
      end
      check("rand_sent", 72'(sent), 72'd200);
      meas_valid = 1'b0;
      tx_ready   = 1'b1;
      cycles     = 0;
      while (exp_q.size() != 0 && cycles < 3000) begin
         step();
         cycles++;
      end
      check("rand_drain", 72'(exp_q.size()), 72'd0);
      step();

      // Reset in the middle of a frame, after DATA2 is accepted.
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_meas(48'(100 + i), 5'd1, 5'd0);
         step();
      end
      meas_valid = 1'b0;
      step();
      check("pre_rst_level", 72'(fifo_level), 72'd3);
      check("pre_rst_busy", 72'(busy), 72'd1);
      tx_ready = 1'b1;
      repeat (4) step();
      check("pre_rst_valid", 72'(tx_valid), 72'd1);
      check("pre_rst_level2", 72'(fifo_level), 72'd3);
      tx_ready = 1'b0;
      reset    = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_valid", 72'(tx_valid), 72'd0);
      check("mid_rst_busy", 72'(busy), 72'd0);
      check("mid_rst_level", 72'(fifo_level), 72'd0);
      check("mid_rst_data", 72'(tx_data), 72'd0);
      step();
      check("post_rst_idle", 72'(tx_valid), 72'd0);
      tx_ready    = 1'b1;
      base_frames = frames_done;
      drive_meas(48'd7, 5'd3, 5'd12);
      exp_q.push_back(make_frame(56'd215, 8'h00));
      step();
      meas_valid = 1'b0;
      wait_frames(base_frames + 1, 40);
      step();
      check("final_busy", 72'(busy), 72'd0);
      check("final_queue", 72'(exp_q.size()), 72'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
